decode_queue: RTL and testbench
===============================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 The block SHALL provide parameter XLEN, default 32, meaning the width of the PC and the immediate datapath (32 or 64).
REQ-002 The block SHALL provide parameter DEPTH, default 4, meaning the number of instruction entries (power of two, at least 2).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  fetch presents an instruction.
REQ-007 in_ready  output  1  queue can accept an instruction this cycle.
REQ-008 in_pc  input  XLEN  PC of the presented instruction.
REQ-009 in_instr  input  32  raw instruction word.
REQ-010 flush  input  1  synchronous discard of all entries (redirect or trap).
REQ-011 out_valid  output  1  head entry is valid.
REQ-012 out_ready  input  1  issue/scoreboard accepts the head entry (low means stall).
REQ-013 out_pc  output  XLEN  PC of the head entry.
REQ-014 out_instr  output  32  raw head instruction.
REQ-015 out_opcode  output  7 (instr[6:0]); out_funct3  output  3 (instr[14:12]); out_rs1, out_rs2, out_rd  output  5 each (instr[19:15], [24:20], [11:7]).
REQ-016 out_imm  output  XLEN  format-selected, sign-extended immediate.
REQ-017 out_illegal  output  1  head instr[1:0] != 2'b11.
REQ-018 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-019 The block SHALL be a circular FIFO with head and tail pointers that wrap modulo DEPTH, plus an occupancy counter ranging from 0 to DEPTH.
REQ-020 The block SHALL drive in_ready = (count != DEPTH), with no combinational dependence on out_ready.
REQ-021 An enqueue SHALL occur when in_valid && in_ready && !flush: the tail entry is written and tail advances at the clock edge.
REQ-022 A dequeue SHALL occur when out_valid && out_ready && !flush: head advances at the clock edge.
REQ-023 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-024 The block SHALL drive out_valid = (count != 0) and SHALL NOT bypass: an instruction enqueued at edge N is visible on the outputs no earlier than after edge N.
REQ-025 All out_* fields SHALL be combinational from the head entry, and SHALL be forced to zero while count == 0.
REQ-026 Immediate selection by opcode SHALL be:
- I-type for 0010011, 0000011, 1100111, 1110011: instr[31:20].
- S-type for 0100011: {instr[31:25], instr[11:7]}.
- B-type for 1100011: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U-type for 0110111, 0010111: {instr[31:12], 12'b0}.
- J-type for 1101111: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Any other opcode: 0.
- All results are sign-extended to XLEN.
REQ-027 Flush SHALL set count, head and tail to 0 at the next edge, and SHALL take priority over any same-cycle enqueue or dequeue (the incoming instruction is dropped).
REQ-028 When full with out_ready high, the block SHALL dequeue only, since in_ready is low; in_ready rises the following cycle.
REQ-029 Holding out_ready low SHALL keep all out_* fields stable indefinitely.
REQ-030 Storage contents SHALL not affect outputs except through valid entries.

Reset
REQ-031 Asserting rst SHALL immediately clear head, tail and count, giving out_valid = 0, all out_* = 0 and in_ready = 1, regardless of any in-flight handshake.
REQ-032 Entry storage need not be reset.
REQ-033 The first enqueue SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-034 Reset then single instruction: in_instr=32'h00500093 (addi x1,x0,5), in_pc=32'h100, out_ready=1 -> the next cycle shows out_valid=1, out_rd=1, out_rs1=0, out_imm=5, out_pc=32'h100; the cycle after shows count=0.
REQ-035 Fill with out_ready=0, enqueuing 4 instructions -> count=4, in_ready=0, and a 5th in_valid is not accepted; raising out_ready for 1 cycle gives count=3 and in_ready=1.
REQ-036 Wrap-around: stream 10 instructions with out_ready toggling 1/0 -> output order matches input order and pointers wrap with no loss or duplication.
REQ-037 Flush while count=3 with in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, and the incoming instruction is absent.
REQ-038 Immediate formats: beq with offset -4 (32'hFE000EE3) -> out_imm=32'hFFFFFFFC; lui 32'h123450B7 -> out_imm=32'h12345000; with XLEN=64, the same beq -> out_imm=64'hFFFFFFFFFFFFFFFC.
REQ-039 Async reset asserted mid-stream with count=2 -> out_valid=0 and count=0 before the next clock edge.

Source files
------------

// File: rtl/decode_queue.sv
// decode_queue
//   Circular instruction queue between fetch and issue. Each entry holds a PC
//   and a raw 32-bit instruction. The head entry is decoded combinationally
//   into opcode, register fields and a format-selected, sign-extended
//   immediate. There is no bypass: an instruction written at an edge is
//   visible on the outputs only after that edge.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   fetch handshake; in_ready = not full
//   in_pc, in_instr     instruction presented by fetch
//   flush               synchronous discard of every entry (redirect / trap)
//   out_valid/out_ready issue handshake; out_valid = not empty
//   out_pc, out_instr   head entry, forced to zero while empty
//   out_opcode, out_funct3, out_rs1, out_rs2, out_rd   decoded head fields
//   out_imm             sign-extended immediate of the head entry
//   out_illegal         head instruction is not a 32-bit encoding
//   count               occupancy, 0..DEPTH
module decode_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [XLEN-1:0]          in_pc,
   input  logic [31:0]              in_instr,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_pc,
   output logic [31:0]              out_instr,
   output logic [6:0]               out_opcode,
   output logic [2:0]               out_funct3,
   output logic [4:0]               out_rs1,
   output logic [4:0]               out_rs2,
   output logic [4:0]               out_rd,
   output logic [XLEN-1:0]          out_imm,
   output logic                     out_illegal,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic          enq;
   logic          deq;
   logic [31:0]   hd_instr;
   logic [XLEN-1:0] hd_pc;
   logic signed [31:0] imm32;

   // in_ready depends only on state so fetch never sees a path through
   // the issue side's out_ready.
   assign in_ready  = (count != (AW+1)'(DEPTH));
   assign out_valid = (count != '0);

   // Flush wins over both handshakes; the word presented alongside it is lost.
   assign enq = in_valid && in_ready && !flush;
   assign deq = out_valid && out_ready && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow is the wrap.
         if (enq) tail <= tail + AW'(1);
         if (deq) head <= head + AW'(1);
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem[tail].pc    <= in_pc;
         mem[tail].instr <= in_instr;
      end
   end

   // Gate the head entry with out_valid so stale storage never leaks out.
   always_comb begin
      hd_instr = '0;
      hd_pc    = '0;
      if (out_valid) begin
         hd_instr = mem[head].instr;
         hd_pc    = mem[head].pc;
      end
   end

   always_comb begin
      imm32 = '0;
      case (hd_instr[6:0])
         7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
            imm32 = {{20{hd_instr[31]}}, hd_instr[31:20]};
         7'b0100011:
            imm32 = {{20{hd_instr[31]}}, hd_instr[31:25], hd_instr[11:7]};
         7'b1100011:
            imm32 = {{19{hd_instr[31]}}, hd_instr[31], hd_instr[7],
                     hd_instr[30:25], hd_instr[11:8], 1'b0};
         7'b0110111, 7'b0010111:
            imm32 = {hd_instr[31:12], 12'b0};
         7'b1101111:
            imm32 = {{11{hd_instr[31]}}, hd_instr[31], hd_instr[19:12],
                     hd_instr[20], hd_instr[30:21], 1'b0};
         default:
            imm32 = '0;
      endcase
   end

   assign out_pc      = hd_pc;
   assign out_instr   = hd_instr;
   assign out_opcode  = hd_instr[6:0];
   assign out_funct3  = hd_instr[14:12];
   assign out_rs1     = hd_instr[19:15];
   assign out_rs2     = hd_instr[24:20];
   assign out_rd      = hd_instr[11:7];
   // Widening a signed value sign-extends (RV64 U-type included).
   assign out_imm     = XLEN'(imm32);
   // An empty queue reports zero here too, not "illegal".
   assign out_illegal = out_valid && (hd_instr[1:0] != 2'b11);

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
   logic [31:0] in_pc, out_pc, in_instr, out_instr, out_imm;
   logic [6:0]  out_opcode;
   logic [2:0]  out_funct3;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic [2:0]  count;

   logic        v64, r64, rdy64, ov64, ill64;
   logic [63:0] pc64, opc64, imm64;
   logic [31:0] instr64, oinstr64;
   logic [6:0]  opc7_64;
   logic [2:0]  f3_64, cnt64;
   logic [4:0]  rs1_64, rs2_64, rd_64;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   decode_queue #(.XLEN(32), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_instr(out_instr), .out_opcode(out_opcode), .out_funct3(out_funct3),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_imm(out_imm), .out_illegal(out_illegal), .count(count));

   decode_queue #(.XLEN(64), .DEPTH(4)) dut64 (
      .clk(clk), .rst(rst), .in_valid(v64), .in_ready(r64),
      .in_pc(pc64), .in_instr(instr64), .flush(1'b0),
      .out_valid(ov64), .out_ready(rdy64), .out_pc(opc64),
      .out_instr(oinstr64), .out_opcode(opc7_64), .out_funct3(f3_64),
      .out_rs1(rs1_64), .out_rs2(rs2_64), .out_rd(rd_64),
      .out_imm(imm64), .out_illegal(ill64), .count(cnt64));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      in_pc = '0; in_instr = '0;
      v64 = 1'b0; rdy64 = 1'b0; pc64 = '0; instr64 = '0;
      #3;
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passes++;
      checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else passes++;
      checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else passes++;
      checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0 || out_illegal !== 1'b0)
         $display("FAIL reset_fields got pc %h instr %h ill %b exp 0", out_pc, out_instr, out_illegal); else passes++;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // First enqueue lands on the first edge after reset release.
   task automatic test_single;
      in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100; out_ready = 1'b1;
      tick;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", out_valid); else passes++;
      checks++; if (out_rd !== 5'd1 || out_rs1 !== 5'd0)
         $display("FAIL single_regs got rd %0d rs1 %0d exp 1 0", out_rd, out_rs1); else passes++;
      checks++; if (out_imm !== 32'd5) $display("FAIL single_imm got %h exp 00000005", out_imm); else passes++;
      checks++; if (out_pc !== 32'h100) $display("FAIL single_pc got %h exp 00000100", out_pc); else passes++;
      checks++; if (out_opcode !== 7'h13 || out_illegal !== 1'b0)
         $display("FAIL single_opcode got %h ill %b exp 13 0", out_opcode, out_illegal); else passes++;
      tick;
      checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0)
         $display("FAIL single_drain got cnt %0d vld %b pc %h exp 0 0 0", count, out_valid, out_pc); else passes++;
   endtask

   task automatic test_fill;
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_pc = 32'h200 + 32'(4*k); in_instr = 32'h00000013 | 32'(k << 7);
         tick;
      end
      in_pc = 32'h210; in_instr = 32'h00000013;
      checks++; if (count !== 3'd4) $display("FAIL fill_count got %0d exp 4", count); else passes++;
      checks++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready got %b exp 0", in_ready); else passes++;
      tick;
      checks++; if (count !== 3'd4 || out_pc !== 32'h200)
         $display("FAIL fill_5th_rejected got cnt %0d pc %h exp 4 00000200", count, out_pc); else passes++;
      out_ready = 1'b1;
      tick;
      in_valid = 1'b0;
      checks++; if (count !== 3'd3 || in_ready !== 1'b1)
         $display("FAIL fill_deq_only got cnt %0d rdy %b exp 3 1", count, in_ready); else passes++;
      for (int k = 1; k < 4; k++) begin
         checks++; if (out_pc !== 32'h200 + 32'(4*k))
            $display("FAIL fill_order got %h exp %h", out_pc, 32'h200 + 32'(4*k)); else passes++;
         tick;
      end
      out_ready = 1'b0;
      checks++; if (count !== 3'd0) $display("FAIL fill_drained got %0d exp 0", count); else passes++;
   endtask

   task automatic test_wrap;
      int sent = 0;
      int recv = 0;
      int ec   = 0;
      bit e_enq, e_deq;
      for (int cyc = 0; cyc < 60 && recv < 10; cyc++) begin
         in_valid  = (sent < 10);
         in_pc     = 32'h300 + 32'(4*sent);
         in_instr  = 32'h00000013 | 32'(sent << 7);
         out_ready = (cyc % 2 == 0);
         checks++; if (count !== 3'(ec)) $display("FAIL wrap_count got %0d exp %0d", count, ec); else passes++;
         if (ec != 0) begin
            checks++; if (out_pc !== 32'h300 + 32'(4*recv) || out_rd !== 5'(recv))
               $display("FAIL wrap_order got pc %h rd %0d exp %h %0d", out_pc, out_rd, 32'h300 + 32'(4*recv), recv);
            else passes++;
         end
         e_enq = in_valid && (ec != 4);
         e_deq = (ec != 0) && out_ready;
         tick;
         if (e_enq) sent++;
         if (e_deq) recv++;
         ec = ec + int'(e_enq) - int'(e_deq);
      end
      in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (recv !== 10 || count !== 3'd0)
         $display("FAIL wrap_complete got recv %0d cnt %0d exp 10 0", recv, count); else passes++;
   endtask

   task automatic test_flush;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_pc = 32'h400 + 32'(4*k); in_instr = 32'h00000013;
         tick;
      end
      checks++; if (count !== 3'd3) $display("FAIL flush_prefill got %0d exp 3", count); else passes++;
      flush = 1'b1; in_valid = 1'b1; in_pc = 32'h4F0; out_ready = 1'b1;
      tick;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'h0)
         $display("FAIL flush_clear got cnt %0d vld %b rdy %b pc %h exp 0 0 1 0", count, out_valid, in_ready, out_pc);
      else passes++;
      tick;
      checks++; if (count !== 3'd0) $display("FAIL flush_dropped got %0d exp 0", count); else passes++;
      in_valid = 1'b1; in_pc = 32'h500;
      tick;
      in_valid = 1'b0;
      checks++; if (count !== 3'd1 || out_pc !== 32'h500)
         $display("FAIL flush_after got cnt %0d pc %h exp 1 00000500", count, out_pc); else passes++;
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
   endtask

   task automatic test_imm;
      logic [31:0] vin  [7] = '{32'hFE000EE3, 32'h123450B7, 32'hFE20AC23, 32'h008000EF,
                                32'hFFF00093, 32'h002081B3, 32'h00000000};
      logic [31:0] vimm [7] = '{32'hFFFFFFFC, 32'h12345000, 32'hFFFFFFF8, 32'h00000008,
                                32'hFFFFFFFF, 32'h00000000, 32'h00000000};
      logic        vill [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [63:0] e64;
      for (int k = 0; k < 7; k++) begin
         in_valid = 1'b1; in_pc = 32'h600; in_instr = vin[k];
         v64 = 1'b1; pc64 = 64'h600; instr64 = vin[k];
         tick;
         in_valid = 1'b0; v64 = 1'b0;
         e64 = {{32{vimm[k][31]}}, vimm[k]};
         checks++; if (out_imm !== vimm[k] || out_illegal !== vill[k])
            $display("FAIL imm32_%0d got %h ill %b exp %h %b", k, out_imm, out_illegal, vimm[k], vill[k]); else passes++;
         checks++; if (imm64 !== e64)
            $display("FAIL imm64_%0d got %h exp %h", k, imm64, e64); else passes++;
         out_ready = 1'b1; rdy64 = 1'b1;
         tick;
         out_ready = 1'b0; rdy64 = 1'b0;
      end
      checks++; if (count !== 3'd0 || cnt64 !== 3'd0)
         $display("FAIL imm_drain got %0d %0d exp 0 0", count, cnt64); else passes++;
   endtask

   task automatic test_async_reset;
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1; in_pc = 32'h700 + 32'(4*k); in_instr = 32'h00000013;
         tick;
      end
      checks++; if (count !== 3'd2) $display("FAIL arst_prefill got %0d exp 2", count); else passes++;
      out_ready = 1'b1;
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1 || out_pc !== 32'h0)
         $display("FAIL arst_immediate got vld %b cnt %0d rdy %b pc %h exp 0 0 1 0", out_valid, count, in_ready, out_pc);
      else passes++;
      in_valid = 1'b0; out_ready = 1'b0;
      tick;
      rst = 1'b0;
      tick;
      checks++; if (count !== 3'd0) $display("FAIL arst_after got %0d exp 0", count); else passes++;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_single;
      test_fill;
      test_wrap;
      test_flush;
      test_imm;
      test_async_reset;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
